// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling over one raster-order frame.
// A half-width line buffer carries the horizontal maxima of each even row.
module relu_maxpool #(
  parameter int BIT_WIDTH = -1,
  parameter int WIDTH     = -1,
  parameter int HEIGHT    = -1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_sof,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] in_val,
  output logic                        out_valid,
  output logic                        out_eof,
  output logic signed [BIT_WIDTH-1:0] out_val
);

  localparam int HW    = WIDTH / 2;
  localparam int HH    = HEIGHT / 2;
  localparam int XW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int AW    = (HW > 1) ? $clog2(HW) : 1;
  localparam int DEPTH = (HW > 0) ? HW : 1;

  localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_BLK_LAST = XW'(2 * HW - 1);
  localparam logic [YW-1:0] Y_BLK_LAST = YW'(2 * HH - 1);

  if (BIT_WIDTH < 2) begin : g_bad_bit_width
    $error("relu_maxpool: BIT_WIDTH must be set and >= 2");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("relu_maxpool: WIDTH must be >= 2");
  end
  if (HEIGHT < 2) begin : g_bad_height
    $error("relu_maxpool: HEIGHT must be >= 2");
  end

  logic [XW-1:0]                x_q, x_d, x_cur;
  logic [YW-1:0]                y_q, y_d, y_cur;
  logic signed [BIT_WIDTH-1:0]  relu_val, h_max, hold_q;
  logic signed [BIT_WIDTH-1:0]  lb_mem [DEPTH];
  logic signed [BIT_WIDTH-1:0]  lb_rd_q;
  logic [AW-1:0]                lb_addr;
  logic                         in_pool, sof_hit, lb_we, lb_re, blk_done, blk_last;
  logic                         p1_valid_q, p1_eof_q, p2_valid_q, p2_eof_q;
  logic signed [BIT_WIDTH-1:0]  p1_a_q, p1_b_q, p2_val_q;
  logic                         out_valid_q, out_eof_q;
  logic signed [BIT_WIDTH-1:0]  out_val_q;

  // A start-of-frame pixel is forced to (0,0) whatever the counters say.
  assign x_cur    = in_sof ? '0 : x_q;
  assign y_cur    = in_sof ? '0 : y_q;
  assign sof_hit  = in_valid & in_sof;
  assign in_pool  = (x_cur <= X_BLK_LAST) && (y_cur <= Y_BLK_LAST);
  assign relu_val = in_val[BIT_WIDTH-1] ? '0 : in_val;
  assign h_max    = (hold_q > relu_val) ? hold_q : relu_val;
  assign lb_addr  = AW'(x_cur >> 1);
  assign lb_we    = in_valid & in_pool &  x_cur[0] & ~y_cur[0];
  assign lb_re    = in_valid & in_pool & ~x_cur[0] &  y_cur[0];
  assign blk_done = in_valid & in_pool &  x_cur[0] &  y_cur[0];
  assign blk_last = (x_cur == X_BLK_LAST) && (y_cur == Y_BLK_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (in_valid) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        y_d = (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
      end else begin
        x_d = x_cur + XW'(1);
        y_d = y_cur;
      end
    end
  end

  // Line buffer: every entry read in an odd row was written in the even row before it.
  always_ff @(posedge clock) begin
    if (lb_we) lb_mem[lb_addr] <= h_max;
    if (lb_re) lb_rd_q <= lb_mem[lb_addr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      hold_q      <= '0;
      p1_valid_q  <= 1'b0;
      p1_eof_q    <= 1'b0;
      p1_a_q      <= '0;
      p1_b_q      <= '0;
      p2_valid_q  <= 1'b0;
      p2_eof_q    <= 1'b0;
      p2_val_q    <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_val_q   <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (in_valid && !x_cur[0]) hold_q <= relu_val;
      p1_valid_q <= blk_done;
      if (blk_done) begin
        p1_a_q   <= lb_rd_q;
        p1_b_q   <= h_max;
        p1_eof_q <= blk_last;
      end
      // The pipeline drains on its own; a new frame only kills results still in flight.
      p2_valid_q <= p1_valid_q & ~sof_hit;
      p2_eof_q   <= p1_eof_q;
      p2_val_q   <= (p1_a_q > p1_b_q) ? p1_a_q : p1_b_q;
      out_valid_q <= p2_valid_q & ~sof_hit;
      out_eof_q   <= p2_valid_q & ~sof_hit & p2_eof_q;
      if (p2_valid_q && !sof_hit) out_val_q <= p2_val_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;
  assign out_val   = out_val_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool: frame-level pooling model plus literal expectations on two
// instances (4x4 and 5x3 frames, 8-bit values).
module tb_relu_maxpool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, sof_a, vld_a, ov_a, oe_a;
  logic signed [7:0] val_a, ovl_a;
  logic              rst_b, sof_b, vld_b, ov_b, oe_b;
  logic signed [7:0] val_b, ovl_b;

  relu_maxpool #(.BIT_WIDTH(8), .WIDTH(4), .HEIGHT(4)) dut_a (
    .clock(clk), .reset(rst_a), .in_sof(sof_a), .in_valid(vld_a), .in_val(val_a),
    .out_valid(ov_a), .out_eof(oe_a), .out_val(ovl_a));

  relu_maxpool #(.BIT_WIDTH(8), .WIDTH(5), .HEIGHT(3)) dut_b (
    .clock(clk), .reset(rst_b), .in_sof(sof_b), .in_valid(vld_b), .in_val(val_b),
    .out_valid(ov_b), .out_eof(oe_b), .out_val(ovl_b));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: whole-frame pixel store, expected pulses queued with their due edge.
  int frm   [2][0:31];
  int pidx  [2];
  int q_val [2][0:15];
  int q_eof [2][0:15];
  int q_due [2][0:15];
  int q_hd  [2];
  int q_tl  [2];
  int last_val [2];

  int got_val [2][0:31];
  int got_eof [2][0:31];
  int n_got   [2];

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int fw(input int id);
    return (id == 0) ? 4 : 5;
  endfunction

  function automatic int fh(input int id);
    return (id == 0) ? 4 : 3;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_step(input int id, input bit rst, input bit vld, input bit sof, input int v);
    int w, h, x, y, p, m;
    w = fw(id);
    h = fh(id);
    if (rst) begin
      pidx[id] = 0;
      q_hd[id] = 0;
      q_tl[id] = 0;
      return;
    end
    if (!vld) return;
    if (sof) begin
      pidx[id] = 0;
      q_tl[id] = q_hd[id];
    end
    p = pidx[id];
    x = p % w;
    y = p / w;
    frm[id][p] = (v < 0) ? 0 : v;
    if ((x % 2 == 1) && (y % 2 == 1) && (x < 2 * (w / 2)) && (y < 2 * (h / 2))) begin
      m = max2(max2(frm[id][p], frm[id][p-1]), max2(frm[id][p-w], frm[id][p-w-1]));
      q_val[id][q_tl[id] % 16] = m;
      q_eof[id][q_tl[id] % 16] = ((x == 2 * (w / 2) - 1) && (y == 2 * (h / 2) - 1)) ? 1 : 0;
      q_due[id][q_tl[id] % 16] = cyc + 2;
      q_tl[id]++;
    end
    pidx[id] = (p + 1) % (w * h);
  endtask

  initial begin
    pidx = '{0, 0};
    q_hd = '{0, 0};
    q_tl = '{0, 0};
    forever begin
      @(posedge clk);
      cyc++;
      model_step(0, rst_a, vld_a, sof_a, int'(val_a));
      model_step(1, rst_b, vld_b, sof_b, int'(val_b));
    end
  end

  task automatic check_out(input int id, input bit rst, input bit ov, input bit oe, input int ovl);
    string t;
    int k;
    t = (id == 0) ? "A" : "B";
    if (!rst && ov && n_got[id] < 32) begin
      got_val[id][n_got[id]] = ovl;
      got_eof[id][n_got[id]] = int'(oe);
      n_got[id]++;
    end
    if (rst) begin
      check($sformatf("%s.rst_valid", t), int'(ov), 0);
      check($sformatf("%s.rst_eof", t), int'(oe), 0);
      check($sformatf("%s.rst_val", t), ovl, 0);
      last_val[id] = 0;
    end else if (q_hd[id] != q_tl[id] && q_due[id][q_hd[id] % 16] == cyc) begin
      k = q_hd[id] % 16;
      check($sformatf("%s.pulse_valid", t), int'(ov), 1);
      check($sformatf("%s.pulse_val", t), ovl, q_val[id][k]);
      check($sformatf("%s.pulse_eof", t), int'(oe), q_eof[id][k]);
      last_val[id] = q_val[id][k];
      q_hd[id]++;
    end else begin
      check($sformatf("%s.idle_valid", t), int'(ov), 0);
      check($sformatf("%s.idle_eof", t), int'(oe), 0);
      check($sformatf("%s.hold_val", t), ovl, last_val[id]);
    end
  endtask

  initial begin
    last_val = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      check_out(0, rst_a, ov_a, oe_a, int'(ovl_a));
      check_out(1, rst_b, ov_b, oe_b, int'(ovl_b));
    end
  end

  task automatic send(input int id, input int v, input bit sof);
    @(negedge clk);
    if (id == 0) begin
      vld_a = 1'b1; val_a = 8'(v); sof_a = sof;
    end else begin
      vld_b = 1'b1; val_b = 8'(v); sof_b = sof;
    end
  endtask

  task automatic idle(input int id, input int n);
    repeat (n) begin
      @(negedge clk);
      if (id == 0) begin
        vld_a = 1'b0; sof_a = 1'b0;
      end else begin
        vld_b = 1'b0; sof_b = 1'b0;
      end
    end
  endtask

  // Literal pins on the captured pulses since 'base'; eof expected on each frame's last pulse.
  task automatic expect_log(input string nm, input int id, input int base, input int n_exp,
                            input int per_frame, input int e0, input int e1, input int e2,
                            input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check($sformatf("%s.count", nm), n_got[id] - base, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      check($sformatf("%s.val%0d", nm, i), got_val[id][base + i], e[i]);
      check($sformatf("%s.eof%0d", nm, i), got_eof[id][base + i],
            ((i % per_frame) == per_frame - 1) ? 1 : 0);
    end
  endtask

  int base;
  int mixed [16];

  initial begin
    n_got = '{0, 0};
    rst_a = 1'b1; sof_a = 1'b0; vld_a = 1'b0; val_a = '0;
    rst_b = 1'b1; sof_b = 1'b0; vld_b = 1'b0; val_b = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check("reset.out_valid", int'(ov_a), 0);
    check("reset.out_eof", int'(oe_a), 0);
    check("reset.out_val", int'(ovl_a), 0);

    // 1: plain frame 1..16
    base = n_got[0];
    for (int i = 1; i <= 16; i++) send(0, i, i == 1);
    idle(0, 4);
    expect_log("s1", 0, base, 4, 4, 6, 8, 14, 16);

    // 2: negated frame, then a frame with one mixed-sign block
    base = n_got[0];
    for (int i = 1; i <= 16; i++) send(0, -i, i == 1);
    idle(0, 4);
    expect_log("s2neg", 0, base, 4, 4, 0, 0, 0, 0);
    mixed = '{-5, 3, -1, -2, -7, 2, -3, -4, -9, -10, -11, -12, -13, -14, -15, -16};
    base = n_got[0];
    for (int i = 0; i < 16; i++) send(0, mixed[i], i == 0);
    idle(0, 4);
    expect_log("s2mix", 0, base, 4, 4, 3, 0, 0, 0);

    // 3: frame 1..16 with random valid gaps
    base = n_got[0];
    for (int i = 1; i <= 16; i++) begin
      if ($urandom_range(0, 1) == 1) idle(0, 1 + $urandom_range(0, 2));
      send(0, i, i == 1);
    end
    idle(0, 5);
    expect_log("s3", 0, base, 4, 4, 6, 8, 14, 16);

    // 4: aborted frame restarted by in_sof
    base = n_got[0];
    for (int i = 1; i <= 5; i++) send(0, i, i == 1);
    for (int i = 101; i <= 116; i++) send(0, i, i == 101);
    idle(0, 4);
    expect_log("s4", 0, base, 4, 4, 106, 108, 114, 116);

    // 5: odd 5x3 frame, two frames back to back with only one in_sof
    base = n_got[1];
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 15; i++) send(1, i, (f == 0) && (i == 1));
    idle(1, 4);
    expect_log("s5", 1, base, 4, 2, 7, 9, 7, 9);

    // 6: reset on the edge after the last pixel kills the final pulse
    base = n_got[0];
    for (int i = 1; i <= 16; i++) send(0, i, i == 1);
    @(negedge clk);
    vld_a = 1'b0; sof_a = 1'b0; rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    idle(0, 4);
    expect_log("s6cut", 0, base, 3, 4, 6, 8, 14, 0);
    check("s6.val_after_rst", int'(ovl_a), 0);
    check("s6.valid_after_rst", int'(ov_a), 0);
    base = n_got[0];
    for (int i = 1; i <= 16; i++) send(0, i, 1'b0);
    idle(0, 4);
    expect_log("s6next", 0, base, 4, 4, 6, 8, 14, 16);

    idle(0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
Name: relu_maxpool

Overview:
- Streaming ReLU + 2x2/stride-2 max-pooling stage.
- Sits directly downstream of the batch normalisation stage in the image_processor CNN path.
- Consumes one signed fixed-point feature value per valid cycle in raster order (one channel, one frame of WIDTH x HEIGHT).
- Emits one pooled value per 2x2 block, in raster order of the pooled map.
- Holds one half-width line of horizontal maxima.

Parameters:
- BIT_WIDTH, -1, bit width of input/output values; must be set, elaboration error if < 2.
- WIDTH, -1, input frame width in pixels; must be >= 2.
- HEIGHT, -1, input frame height in lines; must be >= 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_sof  input  1  start-of-frame marker; qualified by in_valid.
- in_valid  input  1  in_val is valid this cycle.
- in_val  input  BIT_WIDTH  signed input value (batch-norm output).
- out_valid  output  1  out_val is valid this cycle; one-cycle pulse per pooled value.
- out_eof  output  1  high together with out_valid on the last pooled value of the frame.
- out_val  output  BIT_WIDTH  signed pooled value, always >= 0.

Behaviour:
- Reset: asynchronous, active-high.
  - out_valid, out_eof, out_val = 0.
  - Column counter x = 0, row counter y = 0.
  - Horizontal hold register = 0; pipeline valid bits cleared.
  - Line buffer contents are not reset (always written before being read).
- Stall: no state advances on cycles with in_valid = 0. Arbitrary gaps are allowed and must not change the output values or their order.
- Counters: advance on each in_valid.
  - x wraps at WIDTH-1 to 0 and increments y.
  - y wraps at HEIGHT-1 to 0, so the next frame starts automatically without in_sof.
- in_sof with in_valid: the sampled pixel is treated as (0,0) regardless of the counters. Partial block state is discarded, and any pooled value not yet emitted from the aborted frame is suppressed.
- in_sof without in_valid: ignored.
- ReLU: r = (in_val < 0) ? 0 : in_val. Signed compare; no width growth.
- Horizontal stage, by x parity:
  - Even x: hold r.
  - Odd x: h = max(hold, r).
  - Pixels with x = WIDTH-1 when WIDTH is odd are dropped.
- Vertical stage, by y parity:
  - Even y: write h to line buffer at index x>>1 (depth WIDTH/2, BIT_WIDTH wide).
  - Odd y: result = max(linebuf[x>>1], h).
  - Rows with y = HEIGHT-1 when HEIGHT is odd are dropped.
- The line buffer may be synchronous-read RAM. The read address is issued on the even-x pixel of an odd row.
- Latency: out_valid is asserted exactly 2 rising edges after the edge that sampled the bottom-right pixel of the block, i.e. (odd x, odd y).
  - Fixed latency, independent of later in_valid gaps.
  - Pipeline drains even if in_valid drops.
- Output rate: at most one out_valid per 2 input pixels. Back-to-back blocks never overlap.
- out_eof: high with the pooled value from block (WIDTH/2-1, HEIGHT/2-1).
- out_val holds its last value while out_valid = 0.
- Reset mid-frame: any in-flight result is discarded and no out_valid pulse appears after reset deasserts.
- Output size per frame: floor(WIDTH/2) * floor(HEIGHT/2) pulses.

Test Plan:
1. WIDTH=4, HEIGHT=4, BIT_WIDTH=8. Feed 1..16 raster, in_sof on first, continuous valid.
   - Required: out_val 6, 8, 14, 16.
   - Each out_valid 2 edges after pixels 6, 8, 14, 16 sampled.
   - out_eof only with 16.
2. Same frame negated (-1..-16).
   - Required: four outputs, all 0 (ReLU).
   - Mixed block {-5, 3, -7, 2} gives 3.
3. Frame 1 with in_valid toggled randomly (about 50% duty).
   - Required: identical values/order to scenario 1, exactly 4 pulses.
   - Pulse spacing respects the 2-edge latency from the sampling edge.
4. Send 5 pixels of 1..16, then in_sof with a new frame of 101..116.
   - Required: no output from the aborted frame.
   - Outputs 106, 108, 114, 116.
5. WIDTH=5, HEIGHT=3, feed 1..15.
   - Required: outputs 7, 9 only (column 4 and row 2 dropped).
   - out_eof with 9; next frame starts correctly without in_sof.
6. Assert reset for 1 cycle on the edge after pixel 16 of scenario 1 is sampled.
   - Required: out_valid stays 0 and out_val is 0 after reset.
   - A following frame produces 6, 8, 14, 16.
